wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_if.sv | 51 +++++
 rtl/wb_arbiter.sv | 179 +++++++++++++++++
 tb/tb_wb_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle.
// Groups the main pipeline writeback, the long-latency unit issue and result
// handshake, and the register-file write port with its status outputs.
// slave  : the arbiter side.
// master : the side driving pipeline and long-latency traffic.
interface wb_arbiter_if #(
   parameter int LU_DEPTH = 4
);
   localparam int CW = $clog2(LU_DEPTH) + 1;

   // main pipeline writeback
   logic          pipe_we;
   logic [4:0]    pipe_rd_s;
   logic [31:0]   pipe_rd_v;

   // long-latency dispatch
   logic          lu_issue;
   logic [4:0]    lu_issue_rd;

   // long-latency result offer
   logic          lu_valid;
   logic [4:0]    lu_rd_s;
   logic [31:0]   lu_rd_v;
   logic          lu_ready;

   // register-file write port and status
   logic          regf_we;
   logic [4:0]    rd_s;
   logic [31:0]   rd_v;
   logic [31:0]   busy;
   logic [CW-1:0] lu_cnt;
   logic          waw_err;

   modport slave (
      input  pipe_we, pipe_rd_s, pipe_rd_v,
      input  lu_issue, lu_issue_rd,
      input  lu_valid, lu_rd_s, lu_rd_v,
      output lu_ready,
      output regf_we, rd_s, rd_v,
      output busy, lu_cnt, waw_err
   );

   modport master (
      output pipe_we, pipe_rd_s, pipe_rd_v,
      output lu_issue, lu_issue_rd,
      output lu_valid, lu_rd_s, lu_rd_v,
      input  lu_ready,
      input  regf_we, rd_s, rd_v,
      input  busy, lu_cnt, waw_err
   );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter.
// Merges main-pipeline writebacks and long-latency unit results onto a single
// registered register-file write port. The pipeline always wins; long-latency
// results that lose arbitration are parked in a small FIFO and drained
// oldest-first. A 32-bit scoreboard tracks registers with an outstanding
// long-latency write, and a sticky flag records pipeline writes to such
// registers (write-after-write hazard).
module wb_arbiter #(
   parameter int LU_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   wb_arbiter_if.slave  bus
);
   localparam int AW = (LU_DEPTH > 1) ? $clog2(LU_DEPTH) : 1;
   localparam int CW = $clog2(LU_DEPTH) + 1;
   localparam int EW = 5 + 32;

   // which source owns the write slot this cycle
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_PIPE = 2'd1,
      SRC_HEAD = 2'd2,
      SRC_BYP  = 2'd3
   } src_e;

   // result buffer storage (contents need no reset; count/pointers gate use)
   logic [EW-1:0] lu_mem [LU_DEPTH];

   // buffer bookkeeping
   logic [CW-1:0] cnt_q,    cnt_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;

   // scoreboard and hazard flag
   logic [31:0]   busy_q,   busy_d;
   logic          waw_q,    waw_d;

   // registered write port
   logic          regf_we_q, regf_we_d;
   logic [4:0]    rd_s_q,    rd_s_d;
   logic [31:0]   rd_v_q,    rd_v_d;

   // selection and handshake
   src_e          src;
   logic          lu_ready;
   logic          pipe_sel;
   logic          lu_acc;
   logic          lu_keep;
   logic          buf_empty;
   logic          enq;
   logic          deq;
   logic          lu_wr;
   logic [EW-1:0] head;
   logic [4:0]    sel_rd_s;
   logic [31:0]   sel_rd_v;
   logic [31:0]   busy_set;
   logic [31:0]   busy_clr;

   // ready depends only on registered state, so no combinational path from lu_valid
   assign lu_ready  = !rst && (cnt_q != CW'(LU_DEPTH));
   assign buf_empty = (cnt_q == '0);
   assign head      = lu_mem[rd_ptr_q];

   // arbitration: pipeline, then buffer head, then direct bypass of a fresh result
   always_comb begin
      src      = SRC_NONE;
      sel_rd_s = 5'd0;
      sel_rd_v = 32'd0;
      pipe_sel = bus.pipe_we && (bus.pipe_rd_s != 5'd0);
      lu_acc   = bus.lu_valid && lu_ready;
      lu_keep  = lu_acc && (bus.lu_rd_s != 5'd0);

      if (pipe_sel) begin
         src      = SRC_PIPE;
         sel_rd_s = bus.pipe_rd_s;
         sel_rd_v = bus.pipe_rd_v;
      end else if (!buf_empty) begin
         // a non-empty buffer blocks bypass so results retire in arrival order
         src      = SRC_HEAD;
         sel_rd_s = head[EW-1:32];
         sel_rd_v = head[31:0];
      end else if (lu_keep) begin
         src      = SRC_BYP;
         sel_rd_s = bus.lu_rd_s;
         sel_rd_v = bus.lu_rd_v;
      end

      deq   = (src == SRC_HEAD);
      enq   = lu_keep && (src != SRC_BYP);
      lu_wr = (src == SRC_HEAD) || (src == SRC_BYP);
   end

   // buffer pointer and occupancy update
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (enq) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (deq) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({enq, deq})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // per-register scoreboard set/clear terms; x0 never tracked
   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_busy
         if (gi == 0) begin : g_zero
            assign busy_set[gi] = 1'b0;
            assign busy_clr[gi] = 1'b0;
         end else begin : g_reg
            assign busy_set[gi] = bus.lu_issue && (bus.lu_issue_rd == 5'(gi));
            assign busy_clr[gi] = lu_wr && (sel_rd_s == 5'(gi));
         end
      end
   endgenerate

   // scoreboard next state (set wins over clear) and hazard detection
   always_comb begin
      busy_d    = (busy_q & ~busy_clr) | busy_set;
      busy_d[0] = 1'b0;
      waw_d     = waw_q;
      if (pipe_sel && busy_q[bus.pipe_rd_s]) begin
         waw_d = 1'b1;
      end
   end

   // write port next state: one-cycle pulse of whatever won arbitration
   always_comb begin
      regf_we_d = (src != SRC_NONE);
      rd_s_d    = sel_rd_s;
      rd_v_d    = sel_rd_v;
   end

   // result buffer write
   always_ff @(posedge clk) begin
      if (enq) begin
         lu_mem[wr_ptr_q] <= {bus.lu_rd_s, bus.lu_rd_v};
      end
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         busy_q    <= '0;
         waw_q     <= 1'b0;
         regf_we_q <= 1'b0;
         rd_s_q    <= 5'd0;
         rd_v_q    <= 32'd0;
      end else begin
         cnt_q     <= cnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         busy_q    <= busy_d;
         waw_q     <= waw_d;
         regf_we_q <= regf_we_d;
         rd_s_q    <= rd_s_d;
         rd_v_q    <= rd_v_d;
      end
   end

   assign bus.lu_ready = lu_ready;
   assign bus.regf_we  = regf_we_q;
   assign bus.rd_s     = rd_s_q;
   assign bus.rd_v     = rd_v_q;
   assign bus.busy     = busy_q;
   assign bus.lu_cnt   = cnt_q;
   assign bus.waw_err  = waw_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed vectors, expected register-file writes
// queued at stimulus time and checked by an independent write monitor.
module tb_wb_arbiter;
   localparam int LU_DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   wb_arbiter_if #(.LU_DEPTH(LU_DEPTH)) bus ();

   wb_arbiter #(.LU_DEPTH(LU_DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] v;
   } wr_t;

   wr_t exp_q[$];
   int  total = 0;
   int  bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   task automatic push(input logic [4:0] rd, input logic [31:0] v);
      wr_t e;
      e.rd = rd;
      e.v  = v;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.pipe_we     = 1'b0;
      bus.pipe_rd_s   = 5'd0;
      bus.pipe_rd_v   = 32'd0;
      bus.lu_issue    = 1'b0;
      bus.lu_issue_rd = 5'd0;
      bus.lu_valid    = 1'b0;
      bus.lu_rd_s     = 5'd0;
      bus.lu_rd_v     = 32'd0;
   endtask

   // write monitor: every register-file write must match the next queued expectation
   always @(negedge clk) begin
      wr_t e;
      if (bus.regf_we !== 1'b0) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL write: unexpected write rd=%0d v=0x%08h, none expected", bus.rd_s, bus.rd_v);
         end else begin
            e = exp_q.pop_front();
            if (bus.regf_we !== 1'b1 || bus.rd_s !== e.rd || bus.rd_v !== e.v) begin
               bad++;
               $display("FAIL write: got we=%b rd=%0d v=0x%08h expected rd=%0d v=0x%08h",
                        bus.regf_we, bus.rd_s, bus.rd_v, e.rd, e.v);
            end else begin
               $display("ok   write: rd=%0d v=0x%08h", bus.rd_s, bus.rd_v);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int li;
      int cyc;
      logic acc;

      idle();
      rst = 1'b1;
      repeat (3) tick();

      // reset state
      chk("rst regf_we",  32'(bus.regf_we),  32'd0);
      chk("rst rd_s",     32'(bus.rd_s),     32'd0);
      chk("rst rd_v",     bus.rd_v,          32'd0);
      chk("rst busy",     bus.busy,          32'd0);
      chk("rst lu_cnt",   32'(bus.lu_cnt),   32'd0);
      chk("rst waw_err",  32'(bus.waw_err),  32'd0);
      chk("rst lu_ready", 32'(bus.lu_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("post-rst lu_ready", 32'(bus.lu_ready), 32'd1);

      // single pipeline write
      bus.pipe_we   = 1'b1;
      bus.pipe_rd_s = 5'd5;
      bus.pipe_rd_v = 32'hDEADBEEF;
      push(5'd5, 32'hDEADBEEF);
      tick();
      idle();
      chk("A regf_we pulse", 32'(bus.regf_we), 32'd1);
      tick();
      chk("A regf_we drop", 32'(bus.regf_we), 32'd0);

      // long-latency issue then bypass write
      bus.lu_issue    = 1'b1;
      bus.lu_issue_rd = 5'd7;
      tick();
      idle();
      chk("B busy7 set", 32'(bus.busy[7]), 32'd1);
      tick();
      tick();
      chk("B busy7 held", 32'(bus.busy[7]), 32'd1);
      bus.lu_valid = 1'b1;
      bus.lu_rd_s  = 5'd7;
      bus.lu_rd_v  = 32'h11;
      push(5'd7, 32'h11);
      chk("B lu_ready", 32'(bus.lu_ready), 32'd1);
      tick();
      idle();
      chk("B busy7 clear", 32'(bus.busy[7]), 32'd0);
      chk("B lu_cnt", 32'(bus.lu_cnt), 32'd0);

      // pipeline saturating the port while five results are offered
      for (int i = 1; i <= 6; i++) push(5'(i), 32'h100 + 32'(i));
      for (int j = 1; j <= 5; j++) push(5'(10 + j), 32'h200 + 32'(j));
      li  = 0;
      cyc = 0;
      while (li < 5 && cyc < 20) begin
         bus.pipe_we   = (cyc < 6);
         bus.pipe_rd_s = (cyc < 6) ? 5'(cyc + 1) : 5'd0;
         bus.pipe_rd_v = (cyc < 6) ? 32'h100 + 32'(cyc + 1) : 32'd0;
         bus.lu_valid  = 1'b1;
         bus.lu_rd_s   = 5'(11 + li);
         bus.lu_rd_v   = 32'h201 + 32'(li);
         if (cyc == 4) begin
            chk("C full lu_cnt", 32'(bus.lu_cnt), 32'd4);
            chk("C full lu_ready", 32'(bus.lu_ready), 32'd0);
         end
         acc = bus.lu_ready;
         tick();
         if (acc) li++;
         cyc++;
      end
      idle();
      chk("C all accepted", 32'(li), 32'd5);
      chk("C accept cycles", 32'(cyc), 32'd8);
      chk("C lu_cnt after", 32'(bus.lu_cnt), 32'd3);
      for (int k = 2; k >= 0; k--) begin
         tick();
         chk("C drain lu_cnt", 32'(bus.lu_cnt), 32'(k));
      end

      // same-cycle re-issue and dequeue of the same destination
      bus.lu_issue    = 1'b1;
      bus.lu_issue_rd = 5'd9;
      tick();
      idle();
      bus.pipe_we   = 1'b1;
      bus.pipe_rd_s = 5'd1;
      bus.pipe_rd_v = 32'h55;
      bus.lu_valid  = 1'b1;
      bus.lu_rd_s   = 5'd9;
      bus.lu_rd_v   = 32'h99;
      push(5'd1, 32'h55);
      push(5'd9, 32'h99);
      tick();
      idle();
      chk("D lu_cnt queued", 32'(bus.lu_cnt), 32'd1);
      chk("D busy9 pending", 32'(bus.busy[9]), 32'd1);
      bus.lu_issue    = 1'b1;
      bus.lu_issue_rd = 5'd9;
      tick();
      idle();
      chk("D busy9 set wins", 32'(bus.busy[9]), 32'd1);
      chk("D lu_cnt drained", 32'(bus.lu_cnt), 32'd0);

      // writes to x0 from both sources are dropped
      bus.pipe_we   = 1'b1;
      bus.pipe_rd_s = 5'd0;
      bus.pipe_rd_v = 32'hAA;
      bus.lu_valid  = 1'b1;
      bus.lu_rd_s   = 5'd0;
      bus.lu_rd_v   = 32'hBB;
      chk("F lu_ready before", 32'(bus.lu_ready), 32'd1);
      tick();
      idle();
      chk("F regf_we", 32'(bus.regf_we), 32'd0);
      chk("F lu_cnt", 32'(bus.lu_cnt), 32'd0);
      chk("F lu_ready after", 32'(bus.lu_ready), 32'd1);

      // pipeline write to a busy register
      bus.lu_issue    = 1'b1;
      bus.lu_issue_rd = 5'd3;
      tick();
      idle();
      chk("E busy3 set", 32'(bus.busy[3]), 32'd1);
      chk("E waw before", 32'(bus.waw_err), 32'd0);
      bus.pipe_we   = 1'b1;
      bus.pipe_rd_s = 5'd3;
      bus.pipe_rd_v = 32'h33;
      push(5'd3, 32'h33);
      tick();
      idle();
      chk("E waw set", 32'(bus.waw_err), 32'd1);
      chk("E busy3 kept", 32'(bus.busy[3]), 32'd1);
      tick();
      chk("E waw held", 32'(bus.waw_err), 32'd1);

      // reset with a result still buffered
      bus.pipe_we   = 1'b1;
      bus.pipe_rd_s = 5'd2;
      bus.pipe_rd_v = 32'h22;
      bus.lu_valid  = 1'b1;
      bus.lu_rd_s   = 5'd20;
      bus.lu_rd_v   = 32'h2020;
      push(5'd2, 32'h22);
      tick();
      idle();
      chk("R lu_cnt before", 32'(bus.lu_cnt), 32'd1);
      rst = 1'b1;
      tick();
      chk("R regf_we",  32'(bus.regf_we),  32'd0);
      chk("R rd_s",     32'(bus.rd_s),     32'd0);
      chk("R rd_v",     bus.rd_v,          32'd0);
      chk("R busy",     bus.busy,          32'd0);
      chk("R lu_cnt",   32'(bus.lu_cnt),   32'd0);
      chk("R waw_err",  32'(bus.waw_err),  32'd0);
      chk("R lu_ready", 32'(bus.lu_ready), 32'd0);
      rst = 1'b0;
      tick();
      chk("R no write after", 32'(bus.regf_we), 32'd0);
      chk("R lu_cnt after", 32'(bus.lu_cnt), 32'd0);

      repeat (3) tick();
      chk("all writes seen", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
